// File: rtl/beta_loader.sv
// beta_loader: boot-time loader sitting in front of the beta core.
// It takes a byte stream of commands:
//   'I' addr16 cnt16 payload : write cnt words of IW bits into instruction memory
//   'D' addr16 cnt16 payload : write cnt words of DW bits into data memory
//   'G'                      : release the core from reset (loader then idles for good)
// Any other header byte halts the loader in an error state until RESET.
// Ports:
//   clk, RESET (sync, active-low)
//   in_valid/in_data/in_ready               byte stream handshake
//   imem_we/imem_addr/imem_wdata            instruction memory write port
//   dmem_we/dmem_addr/dmem_wdata            data memory write port
//   cpu_reset                               active-high reset to the core
//   load_done/load_error                    status
module beta_loader #(
   parameter int IMEM_AW = 10,
   parameter int DMEM_AW = 8,
   parameter int IW      = 32,
   parameter int DW      = 128
) (
   input  logic               clk,
   input  logic               RESET,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic               in_ready,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [IW-1:0]      imem_wdata,
   output logic               dmem_we,
   output logic [DMEM_AW-1:0] dmem_addr,
   output logic [DW-1:0]      dmem_wdata,
   output logic               cpu_reset,
   output logic               load_done,
   output logic               load_error
);

   localparam int SW  = (IW > DW) ? IW : DW;
   localparam int BCW = $clog2(SW / 8) + 1;
   localparam logic [BCW-1:0] ILAST = BCW'(IW / 8 - 1);
   localparam logic [BCW-1:0] DLAST = BCW'(DW / 8 - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO, S_PAYLOAD, S_RUN, S_ERROR
   } state_t;

   state_t             state_q, state_d;
   logic               tgt_q, tgt_d;          // 1 = dmem target
   logic [15:0]        addr_q, addr_d;
   logic [15:0]        cnt_q, cnt_d;
   logic [BCW-1:0]     bcnt_q, bcnt_d;
   // Holds all previously accepted payload bytes; the incoming byte completes the word.
   logic [SW-9:0]      word_q, word_d;
   logic [SW-1:0]      full;
   logic               imem_we_q, imem_we_d;
   logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
   logic [IW-1:0]      imem_wdata_q, imem_wdata_d;
   logic               dmem_we_q, dmem_we_d;
   logic [DMEM_AW-1:0] dmem_addr_q, dmem_addr_d;
   logic [DW-1:0]      dmem_wdata_q, dmem_wdata_d;
   logic               accept;

   assign in_ready = RESET && (state_q != S_RUN) && (state_q != S_ERROR);
   assign accept   = in_valid && in_ready;
   assign full     = {word_q, in_data};

   always_comb begin
      state_d      = state_q;
      tgt_d        = tgt_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      bcnt_d       = bcnt_q;
      word_d       = word_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      dmem_we_d    = 1'b0;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      if (accept) begin
         case (state_q)
            S_IDLE: begin
               case (in_data)
                  8'h49:   begin tgt_d = 1'b0; state_d = S_ADDR_HI; end
                  8'h44:   begin tgt_d = 1'b1; state_d = S_ADDR_HI; end
                  8'h47:   state_d = S_RUN;
                  default: state_d = S_ERROR;
               endcase
            end
            S_ADDR_HI: begin addr_d[15:8] = in_data; state_d = S_ADDR_LO; end
            S_ADDR_LO: begin addr_d[7:0]  = in_data; state_d = S_CNT_HI;  end
            S_CNT_HI:  begin cnt_d[15:8]  = in_data; state_d = S_CNT_LO;  end
            S_CNT_LO: begin
               cnt_d[7:0] = in_data;
               bcnt_d     = '0;
               state_d    = ({cnt_q[15:8], in_data} == 16'h0000) ? S_IDLE : S_PAYLOAD;
            end
            S_PAYLOAD: begin
               word_d = full[SW-9:0];
               if (bcnt_q == (tgt_q ? DLAST : ILAST)) begin
                  bcnt_d = '0;
                  addr_d = addr_q + 16'd1;
                  cnt_d  = cnt_q - 16'd1;
                  if (tgt_q) begin
                     dmem_we_d    = 1'b1;
                     dmem_addr_d  = addr_q[DMEM_AW-1:0];
                     dmem_wdata_d = full[DW-1:0];
                  end else begin
                     imem_we_d    = 1'b1;
                     imem_addr_d  = addr_q[IMEM_AW-1:0];
                     imem_wdata_d = full[IW-1:0];
                  end
                  if (cnt_q == 16'd1) state_d = S_IDLE;
               end else begin
                  bcnt_d = bcnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!RESET) begin
         state_q      <= S_IDLE;
         tgt_q        <= 1'b0;
         addr_q       <= '0;
         cnt_q        <= '0;
         bcnt_q       <= '0;
         word_q       <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         tgt_q        <= tgt_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         bcnt_q       <= bcnt_d;
         word_q       <= word_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
      end
   end

   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wdata = dmem_wdata_q;
   assign cpu_reset  = (state_q != S_RUN);
   assign load_done  = (state_q == S_RUN);
   assign load_error = (state_q == S_ERROR);

endmodule

// File: tb/tb_beta_loader.sv
module tb_beta_loader;

   logic         clk = 1'b0;
   logic         RESET;
   logic         in_valid;
   logic [7:0]   in_data;
   logic         in_ready;
   logic         imem_we;
   logic [9:0]   imem_addr;
   logic [31:0]  imem_wdata;
   logic         dmem_we;
   logic [7:0]   dmem_addr;
   logic [127:0] dmem_wdata;
   logic         cpu_reset;
   logic         load_done;
   logic         load_error;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic         isd;
      logic [15:0]  addr;
      logic [127:0] data;
   } wr_t;
   wr_t exp_q[$];

   beta_loader #(.IMEM_AW(10), .DMEM_AW(8), .IW(32), .DW(128)) dut (
      .clk(clk), .RESET(RESET), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .cpu_reset(cpu_reset), .load_done(load_done),
      .load_error(load_error)
   );

   always #5 clk = ~clk;

   // Scoreboard: every write strobe seen must match the oldest expected write.
   always @(negedge clk) begin
      if (imem_we === 1'b1 && dmem_we === 1'b1) begin
         total++; bad++;
         $display("FAIL both_we: imem_we and dmem_we high together");
      end else if (imem_we === 1'b1 || dmem_we === 1'b1) begin
         wr_t e;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: imem_we=%0b dmem_we=%0b with nothing expected", imem_we, dmem_we);
         end else begin
            e = exp_q.pop_front();
            if (e.isd == 1'b0) begin
               if (imem_we !== 1'b1 || imem_addr !== e.addr[9:0] || imem_wdata !== e.data[31:0]) begin
                  bad++;
                  $display("FAIL imem_write: got we=%0b addr=%h data=%h, want addr=%h data=%h",
                           imem_we, imem_addr, imem_wdata, e.addr[9:0], e.data[31:0]);
               end
            end else begin
               if (dmem_we !== 1'b1 || dmem_addr !== e.addr[7:0] || dmem_wdata !== e.data) begin
                  bad++;
                  $display("FAIL dmem_write: got we=%0b addr=%h data=%h, want addr=%h data=%h",
                           dmem_we, dmem_addr, dmem_wdata, e.addr[7:0], e.data);
               end
            end
         end
      end
   end

   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic push(input logic isd, input logic [15:0] a, input logic [127:0] d);
      wr_t e;
      e.isd = isd; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      RESET = 1'b0;
      idle(2);
      RESET = 1'b1;
   endtask

   task automatic test_reset();
      RESET = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      idle(3);
      total++;
      if ({in_ready, imem_we, dmem_we, cpu_reset, load_done, load_error} !== 6'b000100 ||
          imem_addr !== 10'h0 || imem_wdata !== 32'h0 || dmem_addr !== 8'h0 || dmem_wdata !== 128'h0) begin
         bad++;
         $display("FAIL reset_state: rdy=%0b iwe=%0b dwe=%0b cpurst=%0b done=%0b err=%0b ia=%h id=%h da=%h dd=%h, want 0 0 0 1 0 0 and zeros",
                  in_ready, imem_we, dmem_we, cpu_reset, load_done, load_error, imem_addr, imem_wdata, dmem_addr, dmem_wdata);
      end
      RESET = 1'b1;
      idle(1);
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL idle_ready: in_ready=%0b want 1", in_ready);
      end
   endtask

   task automatic check_drained(input string name);
      idle(2);
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL %s_drain: %0d writes outstanding, want 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_imem();
      logic [7:0] s[13] = '{8'h49, 8'h00, 8'h05, 8'h00, 8'h02,
                            8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
      int not_ready = 0;
      push(1'b0, 16'd5, 128'hDEADBEEF);
      push(1'b0, 16'd6, 128'h01234567);
      foreach (s[i]) begin
         if (in_ready !== 1'b1) not_ready++;
         send(s[i]);
      end
      total++;
      if (not_ready != 0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL imem_ready: not-ready cycles=%0d in_ready=%0b, want 0 and 1", not_ready, in_ready);
      end
      check_drained("imem");
   endtask

   task automatic test_dmem();
      logic [7:0] h[5] = '{8'h44, 8'h00, 8'h00, 8'h00, 8'h01};
      logic [127:0] w = 128'haa29df7d196f03aa5e36698ba569b133;
      push(1'b1, 16'd0, w);
      foreach (h[i]) send(h[i]);
      for (int i = 15; i >= 0; i--) send(w[i*8 +: 8]);
      check_drained("dmem");
   endtask

   task automatic test_wrap_zero();
      logic [7:0] h[5] = '{8'h49, 8'h03, 8'hFF, 8'h00, 8'h02};
      logic [7:0] z[5] = '{8'h49, 8'h00, 8'h00, 8'h00, 8'h00};
      push(1'b0, 16'h03FF, 128'h11223344);
      push(1'b0, 16'h0000, 128'hA5C3E10F);
      foreach (h[i]) send(h[i]);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      send(8'hA5); send(8'hC3); send(8'hE1); send(8'h0F);
      check_drained("wrap");
      foreach (z[i]) send(z[i]);
      idle(2);
      total++;
      if (in_ready !== 1'b1 || load_error !== 1'b0) begin
         bad++; $display("FAIL zero_count_idle: in_ready=%0b load_error=%0b, want 1 0", in_ready, load_error);
      end
   endtask

   task automatic test_go();
      total++;
      if (load_done !== 1'b0 || cpu_reset !== 1'b1) begin
         bad++; $display("FAIL go_before: load_done=%0b cpu_reset=%0b, want 0 1", load_done, cpu_reset);
      end
      send(8'h47);
      total++;
      if (load_done !== 1'b1 || cpu_reset !== 1'b0 || in_ready !== 1'b0) begin
         bad++; $display("FAIL go_after: load_done=%0b cpu_reset=%0b in_ready=%0b, want 1 0 0", load_done, cpu_reset, in_ready);
      end
      send(8'h49); send(8'h00); send(8'h00); send(8'h00); send(8'h01);
      send(8'h12); send(8'h34); send(8'h56); send(8'h78);
      idle(2);
      total++;
      if (load_done !== 1'b1 || cpu_reset !== 1'b0 || load_error !== 1'b0) begin
         bad++; $display("FAIL go_sticky: load_done=%0b cpu_reset=%0b load_error=%0b, want 1 0 0", load_done, cpu_reset, load_error);
      end
      check_drained("go");
   endtask

   task automatic test_error();
      do_reset();
      send(8'h58);
      total++;
      if (load_error !== 1'b1 || cpu_reset !== 1'b1 || in_ready !== 1'b0) begin
         bad++; $display("FAIL err_after: load_error=%0b cpu_reset=%0b in_ready=%0b, want 1 1 0", load_error, cpu_reset, in_ready);
      end
      send(8'h47);
      idle(2);
      total++;
      if (load_done !== 1'b0 || cpu_reset !== 1'b1 || load_error !== 1'b1) begin
         bad++; $display("FAIL err_sticky: load_done=%0b cpu_reset=%0b load_error=%0b, want 0 1 1", load_done, cpu_reset, load_error);
      end
   endtask

   task automatic test_reset_mid_and_stall();
      logic [7:0] s[9] = '{8'h49, 8'h00, 8'h10, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
      do_reset();
      send(8'h49); send(8'h00); send(8'h00); send(8'h00); send(8'h01);
      send(8'hDE); send(8'hAD);
      RESET = 1'b0;
      idle(1);
      total++;
      if ({in_ready, imem_we, dmem_we, cpu_reset, load_done, load_error} !== 6'b000100 ||
          imem_addr !== 10'h0 || imem_wdata !== 32'h0) begin
         bad++;
         $display("FAIL mid_reset: rdy=%0b iwe=%0b dwe=%0b cpurst=%0b done=%0b err=%0b ia=%h id=%h, want 0 0 0 1 0 0 zeros",
                  in_ready, imem_we, dmem_we, cpu_reset, load_done, load_error, imem_addr, imem_wdata);
      end
      RESET = 1'b1;
      idle(1);
      push(1'b0, 16'h0010, 128'hCAFEF00D);
      foreach (s[i]) begin
         send(s[i]);
         idle(1);
      end
      check_drained("stall");
      total++;
      if (imem_addr !== 10'h010 || imem_wdata !== 32'hCAFEF00D || imem_we !== 1'b0) begin
         bad++; $display("FAIL hold_values: addr=%h data=%h we=%0b, want 010 cafef00d 0", imem_addr, imem_wdata, imem_we);
      end
   endtask

   initial begin
      test_reset();
      test_imem();
      test_dmem();
      test_wrap_zero();
      test_go();
      test_error();
      test_reset_mid_and_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/beta_loader.md
Name: beta_loader

Overview:
- Boot-time loader directly upstream of the beta core.
- Accepts a byte stream and assembles 32-bit instruction words into instruction memory and 128-bit words into data memory.
- Holds the core in reset until a GO command arrives.
- Replaces simulation-only memory preloading, so encrypted programs and data can be loaded in hardware.

Parameters:
IMEM_AW, 10, instruction memory word-address width
DMEM_AW, 8, data memory word-address width
IW, 32, instruction word width (multiple of 8)
DW, 128, data memory word width (multiple of 8)

Ports:
clk  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-low reset
in_valid  in  1  byte stream valid
in_data  in  8  byte stream data
in_ready  out  1  loader can accept a byte
imem_we  out  1  instruction memory write strobe
imem_addr  out  IMEM_AW  instruction memory word address
imem_wdata  out  IW  instruction word
dmem_we  out  1  data memory write strobe
dmem_addr  out  DMEM_AW  data memory word address
dmem_wdata  out  DW  data word
cpu_reset  out  1  active-high reset to beta core
load_done  out  1  GO received, core running
load_error  out  1  bad header seen, loader halted

Behaviour:
- Byte transfer: a byte is accepted on any rising edge where in_valid && in_ready.
  - Back-to-back acceptance is allowed, one byte per cycle.
  - Cycles with in_valid low do not alter state.
- Reset (RESET==0 at an edge):
  - State IDLE; in_ready=0 during reset.
  - imem_we=dmem_we=0; addresses and wdata=0.
  - cpu_reset=1, load_done=0, load_error=0.
  - Partial word, address and count registers cleared.
  - Applies mid-operation as well; the in-progress word is discarded and never written.
- States: IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, PAYLOAD, RUN, ERROR. in_ready=1 in IDLE through PAYLOAD, 0 in RUN and ERROR.
- IDLE takes a header byte:
  - 0x49 ('I') selects the imem target, then goes to ADDR_HI.
  - 0x44 ('D') selects the dmem target, then goes to ADDR_HI.
  - 0x47 ('G') goes to RUN.
  - Any other byte goes to ERROR.
- ADDR_HI/ADDR_LO: 16-bit big-endian start word address, truncated to the target AW.
- CNT_HI/CNT_LO: 16-bit big-endian word count.
  - Count==0: return to IDLE after CNT_LO; no write.
  - Otherwise go to PAYLOAD.
- PAYLOAD:
  - Each word is IW/8 (imem) or DW/8 (dmem) bytes, big-endian: the first byte lands in the MSBs.
  - On the edge accepting a word's last byte, the target we/addr/wdata are registered. The strobe is high for exactly the following cycle (latency 1 from the last byte), then low unless the next word also completes.
  - The address increments by 1 per word and wraps modulo 2^AW with no error.
  - The count decrements per word; after the last word, return to IDLE.
- Strobe rules:
  - imem_we and dmem_we are never high together.
  - Address and wdata hold their last values when the strobe is low.
- RUN:
  - cpu_reset=0 and load_done=1 from the cycle after the 'G' byte is accepted.
  - The loader stays in RUN until RESET.
- ERROR: load_error=1 from the cycle after the bad header; cpu_reset stays 1 and the loader stays in ERROR until RESET.
- Header bytes inside payload are treated as data, never decoded.

Test Plan:
- Reset then stream 49 00 05 00 02 | DE AD BE EF | 01 23 45 67:
  - One-cycle imem_we at addr 5, wdata 0xDEADBEEF.
  - Then addr 6, wdata 0x01234567.
  - in_ready stays 1; no dmem_we.
- Stream 44 00 00 00 01 followed by 16 bytes AA 29 DF 7D 19 6F 03 AA 5E 36 69 8B A5 69 B1 33:
  - Single dmem_we at addr 0, wdata 0xaa29df7d196f03aa5e36698ba569b133.
- Send 'G' (0x47):
  - cpu_reset falls and load_done rises exactly one cycle after acceptance.
  - in_ready=0 thereafter; further bytes are ignored.
- Send 0x58:
  - load_error=1 next cycle, cpu_reset stays 1, in_ready=0.
  - Subsequent 'G' has no effect until RESET.
- Wrap and zero count, IMEM_AW=10:
  - Stream 49 03 FF 00 02 plus 8 bytes: writes at addr 0x3FF then 0x000.
  - Stream 49 00 00 00 00: no write, returns to IDLE, next 'G' accepted.
- Reset mid-word and stall:
  - Assert RESET low after 2 of 4 payload bytes: no imem_we, all outputs at reset values.
  - Reload with in_valid toggling every other cycle: correct word written, strobe one cycle.
